// File: rtl/mem_pkg.sv
// Shared constants, opcodes and FSM state encoding for the load/store front end
// and the 32 x 16-bit main memory it drives.
package mem_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 32;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapture,
    StClear,
    StResp
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store front end: one request at a time, sequences the memory's registered
// port and returns a held response. Also fills the whole memory on CLEAR.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W:0] CntLast = (ADDR_W + 1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // req_ready is gated by reset so it stays low for the whole reset window.
  assign req_ready  = (state_q == StIdle) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          unique case (req_op)
            OP_READ, OP_WRITE: state_d = StIssue;
            OP_CLEAR: begin
              cnt_d   = '0;
              state_d = StClear;
            end
            default: begin
              rdata_d = '0;
              err_d   = 1'b1;
              state_d = StResp;
            end
          endcase
        end
      end
      StIssue: begin
        mem_addr       = addr_q;
        mem_write      = (op_q == OP_WRITE);
        mem_write_data = wdata_q;
        if (op_q == OP_WRITE) begin
          rdata_d = wdata_q;
          state_d = StResp;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        // Address held so the registered read port keeps returning the same word.
        mem_addr = addr_q;
        rdata_d  = mem_read_data;
        state_d  = StResp;
      end
      StClear: begin
        mem_write      = 1'b1;
        mem_addr       = cnt_q[ADDR_W-1:0];
        mem_write_data = wdata_q;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          rdata_d = wdata_q;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural memory and reference model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_init;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .busy           (busy),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Behavioural main memory: registered read, write on the rising edge.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hA500 + 16'(i);
    end else begin
      if (mem_write) mem[mem_addr] <= mem_write_data;
      mem_read_data <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t wq[$];
  always @(negedge clock) if (mem_write) wq.push_back('{a: mem_addr, d: mem_write_data});

  logic [DATA_W-1:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      OP_READ:  return 3;
      OP_WRITE: return 2;
      OP_CLEAR: return 33;
      default:  return 1;
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
    if (op == OP_WRITE) ref_mem[addr] = wdata;
    if (op == OP_CLEAR) for (int i = 0; i < DEPTH; i++) ref_mem[i] = wdata;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // One full transaction: accept, measure latency, optional back-pressure, handshake.
  task automatic run_req(input string tag, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int hold,
                         input logic [DATA_W-1:0] exp_rdata, input logic exp_err);
    int n;
    wq.delete();
    wait_ready(tag);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = DATA_W'($urandom);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 100);
    chk({tag, " latency"}, 32'(n), 32'(lat_of(op)));
    chk({tag, " rdata"}, 32'(resp_rdata), 32'(exp_rdata));
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = OP_WRITE;
      @(negedge clock);
      chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " hold rdata"}, 32'(resp_rdata), 32'(exp_rdata));
      chk({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    @(negedge clock);
    chk({tag, " resp drop"}, 32'(resp_valid), 32'd0);
    chk({tag, " err drop"}, 32'(resp_err), 32'd0);
    chk({tag, " idle"}, 32'(req_ready), 32'd1);
    if (op == OP_WRITE) begin
      chk({tag, " nwrites"}, 32'(wq.size()), 32'd1);
      if (wq.size() == 1) begin
        chk({tag, " waddr"}, 32'(wq[0].a), 32'(addr));
        chk({tag, " wdata"}, 32'(wq[0].d), 32'(wdata));
      end
    end else if (op == OP_CLEAR) begin
      chk({tag, " nwrites"}, 32'(wq.size()), 32'(DEPTH));
      if (wq.size() == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wq[i].a !== ADDR_W'(i) || wq[i].d !== wdata)
            chk({tag, " clear seq"}, {wq[i].a, wq[i].d}, {ADDR_W'(i), wdata});
        end
      end
    end else begin
      chk({tag, " nwrites"}, 32'(wq.size()), 32'd0);
    end
    model_apply(op, addr, wdata);
  endtask

  typedef struct {
    string             name;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                hold;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, exp;
    int                r;

    vt[0] = '{"wr5",   OP_WRITE, 5'd5,  16'hBEEF, 0, 16'hBEEF, 1'b0};
    vt[1] = '{"rd5",   OP_READ,  5'd5,  16'h0000, 4, 16'hBEEF, 1'b0};
    vt[2] = '{"clr0",  OP_CLEAR, 5'd9,  16'h0000, 0, 16'h0000, 1'b0};
    vt[3] = '{"rd0",   OP_READ,  5'd0,  16'h1111, 0, 16'h0000, 1'b0};
    vt[4] = '{"rd31",  OP_READ,  5'd31, 16'h2222, 1, 16'h0000, 1'b0};
    vt[5] = '{"rd5b",  OP_READ,  5'd5,  16'h3333, 0, 16'h0000, 1'b0};
    vt[6] = '{"rsvd",  OP_RSVD,  5'd7,  16'hCAFE, 2, 16'h0000, 1'b1};

    reset      = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_op     = OP_READ;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'hA500 + 16'(i);

    repeat (2) @(negedge clock);
    mem_init = 1'b0;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_write_data), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post-rst req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 7; i++)
      run_req(vt[i].name, vt[i].op, vt[i].addr, vt[i].wdata, vt[i].hold,
              vt[i].exp_rdata, vt[i].exp_err);

    // Reset in the middle of a CLEAR: words 0..8 written at edges 1..9, then abort.
    run_req("wr20", OP_WRITE, 5'd20, 16'h5A5A, 0, 16'h5A5A, 1'b0);
    wait_ready("clrabort");
    req_valid = 1'b1;
    req_op    = OP_CLEAR;
    req_wdata = 16'h1234;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("clrabort mid mem_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("clrabort mem_write", 32'(mem_write), 32'd0);
    chk("clrabort busy", 32'(busy), 32'd0);
    chk("clrabort resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("clrabort no resp", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 9; i++) ref_mem[i] = 16'h1234;
    run_req("abort rd8", OP_READ, 5'd8, 16'h0, 0, ref_mem[8], 1'b0);
    run_req("abort rd9", OP_READ, 5'd9, 16'h0, 0, ref_mem[9], 1'b0);
    run_req("abort rd20", OP_READ, 5'd20, 16'h0, 0, ref_mem[20], 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      r     = int'($urandom_range(0, 9));
      op    = (r < 4) ? OP_READ : (r < 8) ? OP_WRITE : (r == 8) ? OP_CLEAR : OP_RSVD;
      addr  = ADDR_W'($urandom);
      wdata = DATA_W'($urandom);
      case (op)
        OP_READ:  exp = ref_mem[addr];
        OP_RSVD:  exp = '0;
        default:  exp = wdata;
      endcase
      run_req("rand", op, addr, wdata, int'($urandom_range(0, 3)), exp, op == OP_RSVD);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end sitting directly upstream of the 32 x 16-bit main memory. It accepts one request at a time from the CPU datapath over a valid/ready handshake. It sequences the memory's single-cycle registered read and write port, and returns a held response (read data or write acknowledge) over a second valid/ready handshake. It also provides a bulk CLEAR operation that fills all 32 words with a given value.

## Interface
- ADDR_W, 5, memory address width
- DATA_W, 16, memory data width
- DEPTH, 32, number of words; must equal 2**ADDR_W
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  2  request opcode: 00 READ, 01 WRITE, 10 CLEAR, 11 reserved
- req_addr  in  ADDR_W  word address (ignored for CLEAR)
- req_wdata  in  DATA_W  write data, or the fill value for CLEAR
- resp_valid  out  1  response present; held until accepted
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  DATA_W  READ: memory word; WRITE/CLEAR: echo of req_wdata; reserved op: 0
- resp_err  out  1  high with the response of a reserved opcode only
- busy  out  1  high in every state except IDLE
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_write_data  out  DATA_W  memory write data
- mem_read_data  in  DATA_W  memory read data, registered by the memory one edge after address presentation with mem_write low

## Operation
- States: IDLE, ISSUE, CAPTURE, CLEAR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, addr and wdata into internal registers.
  - Next state: READ/WRITE -> ISSUE; CLEAR -> CLEAR, with clear counter=0; 11 -> RESP with resp_err=1 and resp_rdata=0.
- ISSUE:
  - mem_addr=latched addr.
  - mem_write=1 only for WRITE; mem_write_data=latched wdata.
  - Next state: READ -> CAPTURE; WRITE -> RESP.
- CAPTURE:
  - mem_write=0; mem_addr is held.
  - At the edge, resp_rdata<=mem_read_data; next state RESP.
- CLEAR:
  - mem_write=1, mem_addr=counter, mem_write_data=latched wdata.
  - Counter increments each cycle.
  - After the cycle with counter=DEPTH-1, go to RESP; the counter does not wrap into a second pass.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable.
  - Stay until resp_ready=1, then go to IDLE and clear resp_valid and resp_err.
  - resp_rdata keeps its last value.
- mem_write is 0 in IDLE, CAPTURE and RESP. The memory never sees a write outside ISSUE(WRITE) or CLEAR.
- Requests are not queued. req_valid while busy is ignored and must be held by the requester.
- Memory contents are not part of this block's state.

## Timing
- Reset values while reset is high: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, mem_write=0, mem_addr=0, mem_write_data=0, clear counter=0. req_ready rises in the first cycle after reset deasserts.
- Latency is counted from the accept edge (edge 0) to the first cycle with resp_valid=1:
  - READ: 3 cycles.
  - WRITE: 2 cycles; the memory write happens at edge 1.
  - CLEAR: 33 cycles; writes occur at edges 1..32.
  - Reserved op: 1 cycle.
- If resp_ready=1 in the first RESP cycle, resp_valid lasts exactly one cycle.
- The next accept is possible no earlier than the following IDLE cycle, so back-to-back requests have a minimum spacing of latency+1 cycles.
- Reset asserted mid-CLEAR or mid-WRITE aborts immediately and asynchronously: mem_write drops, and no response is produced. Already-written words stay written.
- Reset asserted in RESP drops resp_valid without a handshake.

## Structure
- Shared package mem_pkg holds:
  - ADDR_W, DATA_W, DEPTH constants.
  - Opcode constants OP_READ=2'b00, OP_WRITE=2'b01, OP_CLEAR=2'b10, OP_RSVD=2'b11.
  - The state encoding.
- Single module with a registered FSM; the memory-port outputs decode combinationally from state and the latched registers. No sub-module is needed. The clear counter is an ADDR_W+1-bit register inside this module.

## Test plan
- Reset release, then WRITE addr 5 data 16'hBEEF -> mem_write=1 for exactly one cycle with mem_addr=5; resp_valid at cycle 2 with resp_rdata=16'hBEEF, resp_err=0.
- READ addr 5 after the above -> resp_valid at cycle 3 with resp_rdata=16'hBEEF; mem_write stays 0 throughout.
- CLEAR with data 16'h0000, then READ addr 0, addr 31 and addr 5 -> all return 16'h0000. CLEAR resp_valid at cycle 33, with exactly 32 write cycles covering addresses 0..31 in order.
- Hold resp_ready=0 for 4 cycles after a READ -> resp_valid and resp_rdata are stable; req_ready=0 and new req_valid is ignored; accepted once resp_ready=1.
- Reserved op 2'b11 -> no memory write; resp_valid at cycle 1 with resp_err=1, resp_rdata=0.
- Assert reset at cycle 10 of a CLEAR with data 16'h1234 -> mem_write=0 and busy=0 immediately, no response. After release, READ addr 8 returns 16'h1234 and READ addr 20 returns its pre-CLEAR value.
